// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with step, parallel load and wrap-or-clamp bounds.
// count, ovf and unf are registered; at_max/at_min decode the registered count.
module param_updown_counter #(
    parameter int                WIDTH    = 8,
    parameter longint unsigned   MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int                SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf
);
    // One extra bit so sums and the MAX_VAL+1 modulus are never truncated.
    localparam logic [WIDTH:0]   LP_MAX   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   LP_MOD   = (WIDTH+1)'(MAX_VAL + 64'd1);
    localparam logic [WIDTH-1:0] LP_MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH:0]   w_cnt;
    logic [WIDTH:0]   w_stp;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_wrap_up;
    logic [WIDTH-1:0] w_wrap_dn;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_next;
    logic             w_ovf;
    logic             w_unf;

    assign w_cnt     = {1'b0, r_count};
    assign w_stp     = ({1'b0, step} > LP_MAX) ? LP_MAX : {1'b0, step};
    assign w_sum     = w_cnt + w_stp;
    assign w_wrap_up = WIDTH'(w_sum - LP_MOD);
    assign w_wrap_dn = WIDTH'(w_cnt + LP_MOD - w_stp);
    assign w_load    = ({1'b0, load_val} > LP_MAX) ? LP_MAX_W : load_val;

    always_comb begin
        w_next = r_count;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        if (up_down) begin
            if (w_sum > LP_MAX) begin
                w_ovf  = 1'b1;
                w_next = (SATURATE != 0) ? LP_MAX_W : w_wrap_up;
            end else begin
                w_next = w_sum[WIDTH-1:0];
            end
        end else begin
            // A clamped step larger than count crosses zero.
            if (w_stp > w_cnt) begin
                w_unf  = 1'b1;
                w_next = (SATURATE != 0) ? '0 : w_wrap_dn;
            end else begin
                w_next = WIDTH'(w_cnt - w_stp);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (load) begin
            r_count <= w_load;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (en) begin
            r_count <= w_next;
            r_ovf   <= w_ovf;
            r_unf   <= w_unf;
        end else begin
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end
    end

    assign count  = r_count;
    assign ovf    = r_ovf;
    assign unf    = r_unf;
    assign at_max = (r_count == LP_MAX_W);
    assign at_min = (r_count == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: three counter configurations share one stimulus stream; a
// monitor compares each against expectations queued by an arithmetic model.
module tb_param_updown_counter;
    logic       clk = 1'b0;
    logic       rst, en, up_down, load;
    logic [7:0] step, load_val;

    logic [3:0] a_cnt, b_cnt;
    logic [7:0] c_cnt;
    logic       a_max, a_min, a_ovf, a_unf;
    logic       b_max, b_min, b_ovf, b_unf;
    logic       c_max, c_min, c_ovf, c_unf;

    always #5 clk = ~clk;

    // A: WIDTH=4 MAX=9 wrap; B: WIDTH=4 MAX=9 clamp; C: WIDTH=8 defaults
    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .step(step[3:0]),
        .load(load), .load_val(load_val[3:0]), .count(a_cnt),
        .at_max(a_max), .at_min(a_min), .ovf(a_ovf), .unf(a_unf));
    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .step(step[3:0]),
        .load(load), .load_val(load_val[3:0]), .count(b_cnt),
        .at_max(b_max), .at_min(b_min), .ovf(b_ovf), .unf(b_unf));
    param_updown_counter #(.WIDTH(8)) u_c (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .step(step),
        .load(load), .load_val(load_val), .count(c_cnt),
        .at_max(c_max), .at_min(c_min), .ovf(c_ovf), .unf(c_unf));

    typedef struct {
        int cnt;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t qa[$], qb[$], qc[$];
    int   ma = 0, mb = 0, mc = 0;
    int   n_chk = 0, n_fail = 0;

    // Behaviour from the rules: clamp inputs, then modular or clamped arithmetic.
    function automatic exp_t model(int cnt, int w, int mx, bit sat, bit r, bit ld,
                                   bit e, bit ud, int stp_raw, int lv_raw);
        int   mask = (1 << w) - 1;
        int   stp  = stp_raw & mask;
        int   lv   = lv_raw & mask;
        exp_t x;
        x.cnt = cnt;
        x.ovf = 1'b0;
        x.unf = 1'b0;
        if (r) x.cnt = 0;
        else if (ld) x.cnt = (lv > mx) ? mx : lv;
        else if (e) begin
            if (stp > mx) stp = mx;
            if (ud) begin
                if (cnt + stp > mx) begin
                    x.ovf = 1'b1;
                    x.cnt = sat ? mx : (cnt + stp) % (mx + 1);
                end else x.cnt = cnt + stp;
            end else begin
                if (stp > cnt) begin
                    x.unf = 1'b1;
                    x.cnt = sat ? 0 : (cnt - stp + mx + 1) % (mx + 1);
                end else x.cnt = cnt - stp;
            end
        end
        return x;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_dut(string tag, int cnt, bit o, bit u, bit amax, bit amin,
                           int mx, exp_t e);
        chk({tag, ".count"},  cnt,  e.cnt);
        chk({tag, ".ovf"},    o,    e.ovf);
        chk({tag, ".unf"},    u,    e.unf);
        chk({tag, ".at_max"}, amax, (e.cnt == mx) ? 1 : 0);
        chk({tag, ".at_min"}, amin, (e.cnt == 0) ? 1 : 0);
        chk({tag, ".ovf_unf_excl"}, (o && u) ? 1 : 0, 0);
    endtask

    // Monitor: the counters present a new result after every clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin e = qa.pop_front(); chk_dut("A", int'(a_cnt), a_ovf, a_unf, a_max, a_min, 9, e); end
            if (qb.size() > 0) begin e = qb.pop_front(); chk_dut("B", int'(b_cnt), b_ovf, b_unf, b_max, b_min, 9, e); end
            if (qc.size() > 0) begin e = qc.pop_front(); chk_dut("C", int'(c_cnt), c_ovf, c_unf, c_max, c_min, 255, e); end
        end
    end

    task automatic drive(bit r, bit ld, int lv, bit e, bit ud, int stp);
        exp_t x;
        @(negedge clk);
        rst = r; load = ld; load_val = 8'(lv); en = e; up_down = ud; step = 8'(stp);
        x = model(ma, 4, 9,   1'b0, r, ld, e, ud, stp, lv); qa.push_back(x); ma = x.cnt;
        x = model(mb, 4, 9,   1'b1, r, ld, e, ud, stp, lv); qb.push_back(x); mb = x.cnt;
        x = model(mc, 8, 255, 1'b0, r, ld, e, ud, stp, lv); qc.push_back(x); mc = x.cnt;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up_down = 1'b0; load = 1'b0; step = '0; load_val = '0;
        drive(1, 0, 0, 0, 0, 0);                        // reset state
        for (int i = 0; i < 12; i++) drive(0, 0, 0, 1, 1, 1);   // 1..9,0,1,2 on A
        drive(0, 1, 2, 0, 0, 0);  drive(0, 0, 0, 1, 0, 5);      // down across zero
        drive(0, 1, 8, 0, 0, 0);  drive(0, 0, 0, 1, 1, 3);  drive(0, 0, 0, 1, 1, 3);
        drive(0, 1, 15, 1, 1, 1); drive(0, 0, 0, 0, 1, 1);      // clamped load, hold
        drive(1, 1, 5, 1, 1, 1);                                // rst beats load
        drive(0, 1, 255, 0, 0, 0); drive(0, 0, 0, 1, 1, 1);     // 255 -> 0 on C
        drive(0, 0, 0, 1, 1, 0);  drive(0, 0, 0, 1, 0, 0);      // step 0
        drive(0, 1, 3, 0, 0, 0);  drive(0, 0, 0, 1, 1, 15); drive(0, 0, 0, 1, 0, 200);
        drive(0, 1, 0, 0, 0, 0);  drive(0, 0, 0, 1, 0, 1);  drive(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 400; i++) begin
            int p = $urandom_range(0, 99);
            int s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
            drive(p < 2, (p >= 2 && p < 12), $urandom_range(0, 255),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, s);
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("queues_drained", qa.size() + qb.size() + qc.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
